// File: rtl/aes_round_engine.sv
// Iterative AES-128 encryption datapath: one full round per clock, with the round
// index driven to an external key scheduler that returns the matching round key.

module aes_sbox (
    input  logic [31:0] sboxw,
    output logic [31:0] new_sboxw
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry x sits at bit offset 8*(255-x); 255-x equals ~x for an 8-bit index.
    function automatic logic [7:0] sub_byte(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    assign new_sboxw = {sub_byte(sboxw[31:24]), sub_byte(sboxw[23:16]),
                        sub_byte(sboxw[15:8]),  sub_byte(sboxw[7:0])};
endmodule

module aes_round_engine #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    output logic [3:0]   rk_round,
    input  logic [127:0] rk_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext
);
    generate
        if (NUM_ROUNDS != 10) begin : g_bad_rounds
            $error("aes_round_engine: only NUM_ROUNDS = 10 (AES-128) is supported");
        end
    endgenerate

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [3:0]     r_round;
    logic [3:0]     w_round_nxt;
    logic [127:0]   r_data;
    logic [127:0]   w_data_nxt;
    logic [127:0]   w_sb;
    logic [127:0]   w_sr;
    logic [127:0]   w_mc;
    logic [127:0]   w_round_out;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte k of the block is [127-8k -: 8]; state element (row r, col c) is byte 4c+r.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        a0 = a[31:24];
        a1 = a[23:16];
        a2 = a[15:8];
        a3 = a[7:0];
        return {xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3),
                (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    genvar gc;
    generate
        for (gc = 0; gc < 4; gc++) begin : g_col
            aes_sbox u_sbox (
                .sboxw     (r_data[127 - 32*gc -: 32]),
                .new_sboxw (w_sb[127 - 32*gc -: 32])
            );
        end
    endgenerate

    assign w_sr = shift_rows(w_sb);
    assign w_mc = {mix_column(w_sr[127:96]), mix_column(w_sr[95:64]),
                   mix_column(w_sr[63:32]),  mix_column(w_sr[31:0])};

    // The final round skips MixColumns.
    assign w_round_out = ((r_round == LAST_ROUND) ? w_sr : w_mc) ^ rk_in;

    always_comb begin
        w_state_nxt = r_state;
        w_round_nxt = r_round;
        w_data_nxt  = r_data;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_data_nxt  = plaintext ^ rk_in;
                    w_round_nxt = 4'd1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_data_nxt = w_round_out;
                if (r_round == LAST_ROUND) begin
                    w_round_nxt = 4'd0;
                    w_state_nxt = DONE;
                end else begin
                    w_round_nxt = r_round + 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_round_nxt = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_round <= 4'd0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_round <= w_round_nxt;
            r_data  <= w_data_nxt;
        end
    end

    assign in_ready   = (r_state == IDLE);
    assign out_valid  = (r_state == DONE);
    assign rk_round   = r_round;
    assign ciphertext = r_data;
endmodule

// File: tb/tb_aes_round_engine.sv
// Directed FIPS-197 vectors against aes_round_engine with a bench-side key scheduler
// (S-box derived from GF(2^8) inversion and the affine map).

module tb_aes_round_engine;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] R0_B  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] R1_B  = 128'ha49c7ff2689f352b6b5bea43026a5049;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [3:0]   rk_round;
    logic [127:0] rk_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;

    logic [7:0]   sb [0:255];
    logic [127:0] rk_tab [0:1][0:15];
    logic         kb;
    int           n_cmp;
    int           n_fail;

    aes_round_engine #(.NUM_ROUNDS(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .rk_round   (rk_round),
        .rk_in      (rk_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext)
    );

    assign rk_in = rk_tab[kb][rk_round];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl1(input logic [7:0] b);
        return {b[6:0], b[7]};
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, r1, r2, r3, r4;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            r1 = rotl1(inv); r2 = rotl1(r1); r3 = rotl1(r2); r4 = rotl1(r3);
            sb[a] = inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
        end
    endtask

    task automatic expand_key(input logic [127:0] key, input int slot);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++) begin
            rk_tab[slot][r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; plaintext = '0; kb = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (rk_round !== 4'd0) begin n_fail++; $display("FAIL reset_rk_round: got %0d want 0", rk_round); end
        n_cmp++; if (ciphertext !== '0) begin n_fail++; $display("FAIL reset_ciphertext: got %h want 0", ciphertext); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_app_b();
        kb = 1'b0; out_ready = 1'b0;
        plaintext = PT_B; in_valid = 1'b1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b_idle_ready: got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (ciphertext !== R0_B) begin n_fail++; $display("FAIL b_round0: got %h want %h", ciphertext, R0_B); end
        n_cmp++; if (rk_round !== 4'd1) begin n_fail++; $display("FAIL b_rk1: got %0d want 1", rk_round); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b_busy_ready: got %b want 0", in_ready); end
        @(negedge clk);
        n_cmp++; if (ciphertext !== R1_B) begin n_fail++; $display("FAIL b_round1: got %h want %h", ciphertext, R1_B); end
        repeat (8) @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b_early_valid: got %b want 0", out_valid); end
        n_cmp++; if (rk_round !== 4'd10) begin n_fail++; $display("FAIL b_rk10: got %0d want 10", rk_round); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b_valid_edge11: got %b want 1", out_valid); end
        n_cmp++; if (ciphertext !== CT_B) begin n_fail++; $display("FAIL b_ct: got %h want %h", ciphertext, CT_B); end
        n_cmp++; if (rk_round !== 4'd0) begin n_fail++; $display("FAIL b_rk_wrap: got %0d want 0", rk_round); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL b_accept: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
    endtask

    task automatic test_app_c();
        kb = 1'b1; out_ready = 1'b0;
        plaintext = PT_C; in_valid = 1'b1;
        n_cmp++; if (rk_round !== 4'd0) begin n_fail++; $display("FAIL c_rk0: got %0d want 0", rk_round); end
        @(negedge clk);
        in_valid = 1'b0;
        for (int r = 1; r <= 10; r++) begin
            n_cmp++; if (rk_round !== 4'(r)) begin n_fail++; $display("FAIL c_rk_seq: got %0d want %0d", rk_round, r); end
            @(negedge clk);
        end
        n_cmp++; if (rk_round !== 4'd0) begin n_fail++; $display("FAIL c_rk_wrap: got %0d want 0", rk_round); end
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL c_valid: got %b want 1", out_valid); end
        n_cmp++; if (ciphertext !== CT_C) begin n_fail++; $display("FAIL c_ct: got %h want %h", ciphertext, CT_C); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        kb = 1'b0; out_ready = 1'b0;
        plaintext = PT_B; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 30 && out_valid !== 1'b1; i++) @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_timeout: got out_valid=%b want 1", out_valid); end
        for (int i = 0; i < 20; i++) begin
            plaintext = PT_C;
            in_valid = i[0];
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || ciphertext !== CT_B || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold: got valid=%b ready=%b ct=%h want 1/0/%h", out_valid, in_ready, ciphertext, CT_B);
            end
        end
        // Output and input offered together: output taken, input waits for IDLE.
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || rk_round !== 4'd0) begin
            n_fail++; $display("FAIL bp_release: got valid=%b ready=%b rk=%0d want 0/1/0", out_valid, in_ready, rk_round);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_queue: got ready=%b valid=%b want 1/0", in_ready, out_valid); end
    endtask

    task automatic test_back_to_back();
        int seen, t1, t2;
        seen = 0; t1 = 0; t2 = 0;
        kb = 1'b0; plaintext = PT_B; in_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (seen == 0) begin
                    t1 = cyc;
                    n_cmp++; if (ciphertext !== CT_B) begin n_fail++; $display("FAIL b2b_ct1: got %h want %h", ciphertext, CT_B); end
                    kb = 1'b1; plaintext = PT_C; seen = 1;
                end else begin
                    t2 = cyc;
                    n_cmp++; if (ciphertext !== CT_C) begin n_fail++; $display("FAIL b2b_ct2: got %h want %h", ciphertext, CT_C); end
                    in_valid = 1'b0; seen = 2;
                end
            end
            if (seen == 2) break;
        end
        n_cmp++; if (seen != 2) begin n_fail++; $display("FAIL b2b_outputs: got %0d want 2", seen); end
        n_cmp++; if (t2 - t1 != 12) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 12", t2 - t1); end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        kb = 1'b0; out_ready = 1'b0;
        plaintext = PT_B; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 20 && rk_round !== 4'd5; i++) @(negedge clk);
        n_cmp++; if (rk_round !== 4'd5) begin n_fail++; $display("FAIL rst_reach_r5: got %0d want 5", rk_round); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_hs: got ready=%b valid=%b want 1/0", in_ready, out_valid); end
        n_cmp++; if (rk_round !== 4'd0 || ciphertext !== '0) begin n_fail++; $display("FAIL rst_async_data: got rk=%0d ct=%h want 0/0", rk_round, ciphertext); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_no_partial: got %b want 0", out_valid); end
        end
        plaintext = PT_B; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 30 && out_valid !== 1'b1; i++) @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || ciphertext !== CT_B) begin n_fail++; $display("FAIL rst_after_ct: got valid=%b ct=%h want 1/%h", out_valid, ciphertext, CT_B); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_busy_ignore();
        kb = 1'b0; out_ready = 1'b0;
        plaintext = PT_B; in_valid = 1'b1;
        @(negedge clk);
        plaintext = PT_C;
        repeat (9) @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 30 && out_valid !== 1'b1; i++) @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || ciphertext !== CT_B) begin n_fail++; $display("FAIL busy_ct: got valid=%b ct=%h want 1/%h", out_valid, ciphertext, CT_B); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || rk_round !== 4'd0) begin
                n_fail++; $display("FAIL busy_not_queued: got ready=%b valid=%b rk=%0d want 1/0/0", in_ready, out_valid, rk_round);
            end
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; plaintext = '0; kb = 1'b0;
        build_sbox();
        expand_key(KEY_B, 0);
        expand_key(KEY_C, 1);
        test_reset();
        test_app_b();
        test_app_c();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        test_busy_ignore();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/aes_round_engine.md
Name: aes_round_engine

Overview:
- Iterative AES-128 encryption datapath, directly downstream of the key scheduler.
- Executes one full AES round per clock and steps the scheduler's round counter.
- Consumes the round key that the scheduler presents for that count.
- Accepts a plaintext block through a ready/valid input handshake and returns the ciphertext through a held ready/valid output handshake.

Parameters:
- NUM_ROUNDS, 10, number of cipher rounds. Only 10 (AES-128) is supported; any other value is a configuration error.

Ports:
- clk  input  1  single system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  plaintext offered
- in_ready  output  1  engine idle, plaintext accepted when in_valid=1
- plaintext  input  128  block; byte 0 = [127:120], column-major, column 0 = [127:96]
- rk_round  output  4  round index driven to the key scheduler (its round counter input)
- rk_in  input  128  round key for index rk_round; combinational from scheduler, valid in the same cycle
- out_valid  output  1  ciphertext valid, held until accepted
- out_ready  input  1  downstream accepts ciphertext
- ciphertext  output  128  result, same byte ordering as plaintext

Behaviour:
- Reset (rst_n=0, asynchronous, any state):
  - state=IDLE, in_ready=1, out_valid=0, rk_round=0.
  - ciphertext=0, internal state register=0.
  - Reset mid-operation abandons the block; no partial output appears.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, rk_round=0.
  - On in_valid=1: data <= plaintext ^ rk_in (initial AddRoundKey with round-0 key); rk_round <= 1; go to RUN.
- RUN, rk_round = r, 1..NUM_ROUNDS:
  - For r < NUM_ROUNDS: data <= MixColumns(ShiftRows(SubBytes(data))) ^ rk_in; rk_round <= r+1.
  - For r = NUM_ROUNDS: data <= ShiftRows(SubBytes(data)) ^ rk_in, with no MixColumns; go to DONE; rk_round <= 0.
- SubBytes uses four aes_sbox instances (32-bit sboxw/new_sboxw each), one per column, all in the same cycle.
- ShiftRows: row i rotated left by i byte positions.
- MixColumns: standard GF(2^8) matrix [2 3 1 1] circulant; xtime reduction poly 0x1b.
- DONE:
  - out_valid=1; ciphertext = data, stable while waiting.
  - On out_ready=1: out_valid <= 0; go to IDLE.
- in_ready=0 in RUN and DONE. in_valid there is ignored and does not queue.
- Latency: 11 clock edges from the accepting edge to out_valid=1.
  - Accept edge: round 0.
  - Edges 1..10: rounds 1..10.
  - out_valid rises after edge 10.
  - Back-to-back throughput: 1 block per 12 cycles with out_ready tied high.
- out_valid and ciphertext never change while out_valid=1 and out_ready=0.
- rk_round never exceeds NUM_ROUNDS. It wraps to 0 on leaving the last round.
- Simultaneous out_ready=1 and in_valid=1 in DONE: output is accepted; the input is not accepted that cycle. It can be accepted next cycle in IDLE.

Test Plan:
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734, bench key-schedule model on rk_round/rk_in -> after accept edge data=193de3bea0f4e22b9ac68d2ae9f84808; after round 1 data=a49c7ff2689f352b6b5bea43026a5049; out_valid after 11 edges with ciphertext 3925841d02dc09fbdc118597196a0b32.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff -> ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a; rk_round sequence 0,1,...,10,0.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> ciphertext and out_valid stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> out_valid drops next edge, in_ready=1.
- Back-to-back: out_ready=1 constantly, in_valid=1 constantly with the App. B then App. C.1 blocks -> two correct ciphertexts, 12 cycles apart.
- Reset mid-run: deassert rst_n during round 5 -> immediately in_ready=1, out_valid=0, rk_round=0, ciphertext=0; the next App. B block after release gives the correct result.
- Input ignored while busy: in_valid with a different plaintext during RUN -> first block's ciphertext unchanged; second block not processed.
